switch_box_param: RTL
=====================

SWITCH_BOX_PARAM -- requirements
Module: switch_box_param

Interface
REQ-001 Parameter NUM_TRACKS, default 4, tracks per side (>=1).
REQ-002 Parameter WIDTH, default 1, bits per track.
REQ-003 Parameter NUM_PE, default 1, PE outputs offered to every output mux (1..5).
REQ-004 Parameter EXCLUDE_SIDE, default 2, side with no driven outputs (0..3).
REQ-005 clk  input  1  single clock; all state updates on rising edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 in_wire  input  4*NUM_TRACKS*WIDTH  track (s,t) at bits [(s*NUM_TRACKS+t)*WIDTH +: WIDTH].
REQ-008 pe_output  input  NUM_PE*WIDTH  PE p at bits [p*WIDTH +: WIDTH].
REQ-009 out_wire  output  4*NUM_TRACKS*WIDTH  same packing as in_wire.
REQ-010 config_en  input  1  write config_data into shadow word config_addr.
REQ-011 config_addr  input  8  config word address for writes and reads.
REQ-012 config_data  input  32  write data.
REQ-013 config_commit  input  1  copy the whole shadow bank into the active bank.
REQ-014 config_rd_en  input  1  read request for shadow word config_addr.
REQ-015 config_rd_data  output  32  registered read data.
REQ-016 config_rd_valid  output  1  high for exactly one cycle, the cycle after config_rd_en.

Function
REQ-017 SEL_W = clog2(3+NUM_PE); SPW = floor(32/SEL_W) selectors per word; NW = ceil(4*NUM_TRACKS/SPW) words.
REQ-018 Selector i = s*NUM_TRACKS+t lives in word i/SPW, bits [(i%SPW)*SEL_W +: SEL_W]; unused upper bits of each word read as 0.
REQ-019 Output (s,t) with selector value k in 0..2 drives in_wire side u=(s+k+1)%4, track (t+(u+3)%4)%NUM_TRACKS.
REQ-020 Selector value 3+p with p<NUM_PE drives pe_output p; any larger value drives all-zero.
REQ-021 Outputs on EXCLUDE_SIDE are constant 0; their selector fields ignore writes and read back 0.
REQ-022 Output muxing uses the active bank only; shadow writes never affect out_wire before a commit.
REQ-023 Writes with config_addr >= NW are ignored; reads at config_addr >= NW return 0 with config_rd_valid still asserted.
REQ-024 Write and commit in the same cycle: the active bank receives the shadow including that cycle's write.
REQ-025 Read and write to the same address in the same cycle: read returns pre-write shadow value.
REQ-026 Read latency is 1 cycle; back-to-back reads are accepted every cycle.

Reset
REQ-027 On reset all shadow and active selectors go to 0, config_rd_data to 0, config_rd_valid to 0.
REQ-028 Reset dominates config_en, config_commit and config_rd_en in the same cycle.
REQ-029 After reset each non-excluded output (s,t) follows in_wire side (s+1)%4 track (t+(s+1+3)%4)%NUM_TRACKS.

Configuration
REQ-030 Macro SB_OUTPUT_REG_EN defined: each out_wire bit is registered; mux result appears one cycle after the input/active-bank change; output registers reset to 0.
REQ-031 Macro SB_OUTPUT_REG_EN undefined: out_wire is purely combinational from in_wire, pe_output and the active bank (zero latency).

Verification (NUM_TRACKS=4, WIDTH=1, NUM_PE=1, EXCLUDE_SIDE=2 unless stated; SEL_W=2, SPW=16, NW=1)
REQ-032 Reset, in_wire side1 track0 = 1, other inputs 0 -> out_wire track(0,0)=1, all side-2 outputs 0.
REQ-033 Write addr0 = 0xFFFFFFFF, no commit -> out_wire unchanged; pulse config_commit -> every non-excluded output equals pe_output[0].
REQ-034 Write addr0 = 0x00000001 with config_commit in the same cycle -> out(0,0) follows in_wire side2 track1 from the next cycle.
REQ-035 After write 0xFFFFFFFF, rd_en addr0 -> next cycle rd_data=0xFF00FFFF, rd_valid=1 for one cycle; rd_en addr5 -> rd_data=0, rd_valid=1.
REQ-036 NUM_PE=2 (SEL_W=3): selector of out(0,0) = 5 and commit -> out(0,0)=0 regardless of inputs; selector = 4 -> out(0,0) = pe_output[1].
REQ-037 Write and commit then assert reset -> out(0,0) reverts to in_wire side1 track0; with SB_OUTPUT_REG_EN, toggling in_wire side1 track0 -> out(0,0) changes exactly one cycle later.

Source files
------------

// File: rtl/switch_box_param_if.sv
`default_nettype none
// ============================================================================
// Module   : switch_box_param_if
// Purpose  : Routing buses and configuration port of the switch box.
// Revision : 1.0
// ============================================================================
interface switch_box_param_if #(
  parameter int NUM_TRACKS = 4,
  parameter int WIDTH      = 1,
  parameter int NUM_PE     = 1
) ();
  logic [4*NUM_TRACKS*WIDTH-1:0] in_wire;
  logic [NUM_PE*WIDTH-1:0]       pe_output;
  logic [4*NUM_TRACKS*WIDTH-1:0] out_wire;
  logic                          config_en;
  logic [7:0]                    config_addr;
  logic [31:0]                   config_data;
  logic                          config_commit;
  logic                          config_rd_en;
  logic [31:0]                   config_rd_data;
  logic                          config_rd_valid;

  modport master (
    output in_wire, pe_output, config_en, config_addr, config_data,
           config_commit, config_rd_en,
    input  out_wire, config_rd_data, config_rd_valid
  );

  modport slave (
    input  in_wire, pe_output, config_en, config_addr, config_data,
           config_commit, config_rd_en,
    output out_wire, config_rd_data, config_rd_valid
  );
endinterface
`default_nettype wire

// File: rtl/switch_box_param.sv
`default_nettype none
// ============================================================================
// Module   : switch_box_param
// Purpose  : Configurable 4-sided switch box with shadow/active selector banks.
//            Define SB_OUTPUT_REG_EN to register every out_wire bit.
// Revision : 1.0
// ============================================================================
module switch_box_param #(
  parameter int NUM_TRACKS   = 4,
  parameter int WIDTH        = 1,
  parameter int NUM_PE       = 1,
  parameter int EXCLUDE_SIDE = 2
) (
  input wire clk,
  input wire reset,
  switch_box_param_if.slave sb
);
  localparam int c_sel_w = $clog2(3 + NUM_PE);
  localparam int c_spw   = 32 / c_sel_w;
  localparam int c_nsel  = 4 * NUM_TRACKS;
  localparam int c_bus   = c_nsel * WIDTH;

  logic [c_sel_w-1:0] r_shadow     [c_nsel];
  logic [c_sel_w-1:0] r_active     [c_nsel];
  logic [c_sel_w-1:0] w_shadow_nxt [c_nsel];
  logic [31:0]        w_rd_word;
  logic [31:0]        r_rd_data;
  logic               r_rd_valid;
  logic [c_bus-1:0]   w_mux;

  // Excluded-side selectors are never written, so they stay at their reset 0.
  always_comb begin
    for (int i = 0; i < c_nsel; i++) begin
      w_shadow_nxt[i] = r_shadow[i];
      if (sb.config_en && (32'(sb.config_addr) == 32'(i / c_spw)) &&
          ((i / NUM_TRACKS) != EXCLUDE_SIDE))
        w_shadow_nxt[i] = sb.config_data[(i % c_spw) * c_sel_w +: c_sel_w];
    end
  end

  // Addresses beyond the last word match no selector and read as zero.
  always_comb begin
    w_rd_word = '0;
    for (int i = 0; i < c_nsel; i++) begin
      if (32'(sb.config_addr) == 32'(i / c_spw))
        w_rd_word[(i % c_spw) * c_sel_w +: c_sel_w] = r_shadow[i];
    end
  end

  // Commit copies the post-write shadow so a same-cycle write is included.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < c_nsel; i++) begin
        r_shadow[i] <= '0;
        r_active[i] <= '0;
      end
      r_rd_data  <= '0;
      r_rd_valid <= 1'b0;
    end else begin
      for (int i = 0; i < c_nsel; i++) begin
        r_shadow[i] <= w_shadow_nxt[i];
        if (sb.config_commit)
          r_active[i] <= w_shadow_nxt[i];
      end
      r_rd_valid <= sb.config_rd_en;
      if (sb.config_rd_en)
        r_rd_data <= w_rd_word;
    end
  end

  assign sb.config_rd_data  = r_rd_data;
  assign sb.config_rd_valid = r_rd_valid;

  for (genvar gi = 0; gi < c_nsel; gi++) begin : g_out
    localparam int c_s  = gi / NUM_TRACKS;
    localparam int c_t  = gi % NUM_TRACKS;
    localparam int c_u0 = (c_s + 1) % 4;
    localparam int c_u1 = (c_s + 2) % 4;
    localparam int c_u2 = (c_s + 3) % 4;
    localparam int c_i0 = (c_u0 * NUM_TRACKS + (c_t + (c_u0 + 3) % 4) % NUM_TRACKS) * WIDTH;
    localparam int c_i1 = (c_u1 * NUM_TRACKS + (c_t + (c_u1 + 3) % 4) % NUM_TRACKS) * WIDTH;
    localparam int c_i2 = (c_u2 * NUM_TRACKS + (c_t + (c_u2 + 3) % 4) % NUM_TRACKS) * WIDTH;

    if (c_s == EXCLUDE_SIDE) begin : g_excl
      assign w_mux[gi*WIDTH +: WIDTH] = '0;
    end else begin : g_drive
      logic [WIDTH-1:0] w_val;
      always_comb begin
        w_val = '0;
        if (r_active[gi] == c_sel_w'(0))
          w_val = sb.in_wire[c_i0 +: WIDTH];
        else if (r_active[gi] == c_sel_w'(1))
          w_val = sb.in_wire[c_i1 +: WIDTH];
        else if (r_active[gi] == c_sel_w'(2))
          w_val = sb.in_wire[c_i2 +: WIDTH];
        else begin
          for (int p = 0; p < NUM_PE; p++) begin
            if (r_active[gi] == c_sel_w'(3 + p))
              w_val = sb.pe_output[p*WIDTH +: WIDTH];
          end
        end
      end
      assign w_mux[gi*WIDTH +: WIDTH] = w_val;
    end
  end

  if (c_spw * c_sel_w < 32) begin : g_pad
    logic w_unused_cfg_bits;
    assign w_unused_cfg_bits = ^sb.config_data[31:c_spw*c_sel_w];
  end

`ifdef SB_OUTPUT_REG_EN
  logic [c_bus-1:0] r_out;
  always_ff @(posedge clk) begin
    if (reset)
      r_out <= '0;
    else
      r_out <= w_mux;
  end
  assign sb.out_wire = r_out;
`else
  assign sb.out_wire = w_mux;
`endif
endmodule
`default_nettype wire
